serial_to_parallel: RTL
=======================

Name: serial_to_parallel

Overview:
- Receive-side counterpart of the parallel-to-serial shifter. Consumes its LSB-first serial bit stream and rebuilds words of run-time-selectable width.
- A frame strobe marks the first bit of each word.
- Assembled words go into an output holding register with a valid/ready handshake, so downstream logic may stall.
- Sticky status flags report overrun and truncated frames.

Parameters:
- max_width, 16, largest word in bits; legal values 2, 4, 8, 16, 32, 64.
- cnt_bits, clog2(max_width), width of the bit counter and of the width port; derived, do not override.

Ports:
- reset  input  1  asynchronous, active-low reset.
- clock  input  1  rising-edge clock.
- width  input  cnt_bits  bits per word, sampled at sync; 0 encodes max_width.
- sync  input  1  high in the cycle carrying bit 0 of a word.
- in  input  1  serial data, LSB first, one bit per clock.
- clear_flags  input  1  synchronous clear of overrun and frame_error.
- data  output  max_width  assembled word, zero-extended above the active width.
- valid  output  1  data holds an unconsumed word.
- ready  input  1  downstream accepts data when valid && ready.
- busy  output  1  a word is being shifted in.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.
- frame_error  output  1  sticky: sync arrived before the current word completed.

Behaviour:
- Reset:
  - Asynchronous and active-low, taking effect without a clock edge.
  - All registers clear: data=0, valid=0, busy=0, overrun=0, frame_error=0, FSM=IDLE, counter=0.
  - After reset deasserts, the first rising edge is a normal operating edge.
  - Reset mid-word discards the partial word silently; no flags are set.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - sync=1: capture in into shift bit 0; latch width as wlen (0 becomes max_width); counter=1.
  - Then go to SHIFT, or complete immediately if wlen==1.
  - sync=0: stay; in is ignored.
- SHIFT:
  - Each clock: shift[counter]=in; counter increments.
  - The word is complete on the clock where counter+1 == wlen.
  - On completion, counter returns to 0 and the FSM returns to IDLE.
  - Counter arithmetic is done in cnt_bits+1 bits so that wlen=max_width does not wrap.
- sync during SHIFT:
  - Set frame_error.
  - Discard the partial word.
  - Restart as an IDLE sync: the bit in that cycle becomes bit 0 and width is resampled.
- Completion and holding register:
  - On the completing edge the word is offered to the holding register.
  - If valid==0, or (valid && ready) in the same cycle: data = word with bits >= wlen zeroed; valid=1.
  - Otherwise keep the old data, drop the new word, and set overrun.
- Handshake:
  - valid && ready with no completion in that cycle: valid=0. data keeps its value.
  - data is stable while valid=1 && ready=0.
- Timing:
  - busy is high in every cycle where the FSM != IDLE.
  - Latency: sync at cycle 0 means valid rises at the edge ending cycle wlen-1, so valid is seen in cycle wlen.
  - Back-to-back words are supported: sync on the cycle after the last bit, with no gap cycle.
- Flags:
  - clear_flags=1 clears both flags.
  - If a set event and clear_flags occur in the same cycle, set wins.
- width changes outside a sync cycle have no effect on the word in progress.

Optional Feature:
- Macro: S2P_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PARITY for one cycle and samples an even-parity bit on in.
  - Completion, and therefore valid, is delayed by one cycle (valid seen in cycle wlen+1).
  - A mismatch sets the added sticky output parity_error. It is cleared by clear_flags; set wins.
  - The word is still delivered.
  - sync in the PARITY cycle is a frame_error, treated as in SHIFT.
- Undefined: no PARITY state and no parity_error port. Latency is as stated under Behaviour.

Decomposition:
- Shared package holds:
  - FSM state encoding (S2P_IDLE, S2P_SHIFT, S2P_PARITY).
  - A clog2-style bit-count function shared with the parallel-to-serial block.
  - The legal max_width set.
- One natural sub-module, s2p_hold_reg: the valid/ready holding register with overrun detection. It takes word, word_strobe and ready, and produces data, valid and overrun_set.

Test Plan:
- Default width=0 (16 bits): stream 0xA5C3 LSB-first with sync on bit 0, ready=1 -> valid in cycle 16, data=0xA5C3, busy high cycles 1-15.
- width=5: stream 0b10110, then back-to-back 0b00011 with sync on the next cycle -> two valid pulses 5 cycles apart, data=0x0016 then 0x0003, upper bits zero, no flags.
- ready=0: two complete width=4 words 0x9 then 0x6 -> data stays 0x9, valid=1, overrun=1. Then ready=1 for one cycle -> valid=0. clear_flags -> overrun=0.
- width=8: sync again after 3 bits, then 8 bits 0x5A -> frame_error=1, data=0x5A; the partial word is never delivered.
- Reset low mid-word at bit 6 of 16, without a clock edge -> outputs zero immediately. After release, a fresh 0x1234 frame -> data=0x1234, flags clear.
- With S2P_PARITY_EN, width=8: 0x0F with parity 0 -> valid in cycle 9, parity_error=0. 0x07 with parity 0 -> parity_error=1, data=0x07.

Source files
------------

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared state encoding, counter sizing and legal word widths for the serial/parallel shifters.
package s2p_pkg;
  typedef enum logic [1:0] {S2P_IDLE, S2P_SHIFT, S2P_PARITY} s2p_state_t;
  function automatic int s2p_bits(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic bit s2p_legal_width(input int w);
    return w inside {2, 4, 8, 16, 32, 64};
  endfunction
endpackage

// File: rtl/s2p_hold_reg.sv
// s2p_hold_reg: valid/ready output holding register; flags a completed word that finds it full.
module s2p_hold_reg #(
  parameter int w = 16
) (
  input  logic         reset,
  input  logic         clock,
  input  logic [w-1:0] word,
  input  logic         word_strobe,
  input  logic         ready,
  output logic [w-1:0] data,
  output logic         valid,
  output logic         overrun_set
);
  logic [w-1:0] data_q, data_d;
  logic valid_q, valid_d, accept;
  always_comb begin
    accept = word_strobe && (!valid_q || ready);
    overrun_set = word_strobe && valid_q && !ready;
    data_d = accept ? word : data_q;
    valid_d = accept || (valid_q && !ready);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
    end
  assign data = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: rebuilds LSB-first serial words framed by sync into a valid/ready holding register.
// Define S2P_PARITY_EN to add a trailing even-parity bit per word and the parity_error flag.
module serial_to_parallel import s2p_pkg::*; #(
  parameter int max_width = 16,
  localparam int cnt_bits = s2p_bits(max_width)
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [cnt_bits-1:0] width,
  input  logic                sync,
  input  logic                in,
  input  logic                clear_flags,
  output logic [max_width-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                busy,
  output logic                overrun,
  output logic                frame_error
`ifdef S2P_PARITY_EN
  ,
  output logic                parity_error
`endif
);
  localparam logic [cnt_bits:0] one = (cnt_bits + 1)'(1);
  s2p_state_t state_q, state_d;
  logic [cnt_bits:0] cnt_q, cnt_d, wlen_q, wlen_d, wlen_in;
  logic [max_width-1:0] shift_q, shift_d;
  logic overrun_q, overrun_d, frame_error_q, frame_error_d;
  logic parity_error_q, parity_error_d, parity_set;
  logic frame_set, overrun_set, word_strobe, done;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S2P_IDLE;
      cnt_q <= '0;
      wlen_q <= '0;
      shift_q <= '0;
      overrun_q <= 1'b0;
      frame_error_q <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wlen_q <= wlen_d;
      shift_q <= shift_d;
      overrun_q <= overrun_d;
      frame_error_q <= frame_error_d;
      parity_error_q <= parity_error_d;
    end
  // Clearing the shifter at sync keeps bits above wlen zero without a separate mask.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wlen_d = wlen_q;
    shift_d = shift_q;
    frame_set = 1'b0;
    parity_set = 1'b0;
    done = 1'b0;
    wlen_in = (width == '0) ? (cnt_bits + 1)'(max_width) : {1'b0, width};
    if (sync) begin
      frame_set = state_q != S2P_IDLE;
      shift_d = '0;
      shift_d[0] = in;
      wlen_d = wlen_in;
      done = wlen_in == one;
      cnt_d = done ? '0 : one;
      state_d = done ? S2P_IDLE : S2P_SHIFT;
    end else if (state_q == S2P_SHIFT) begin
      shift_d[cnt_q[cnt_bits-1:0]] = in;
      done = cnt_q + one == wlen_q;
      cnt_d = done ? '0 : cnt_q + one;
      state_d = done ? S2P_IDLE : S2P_SHIFT;
    end else if (state_q == S2P_PARITY) begin
      parity_set = (^shift_q) != in;
      state_d = S2P_IDLE;
    end
`ifdef S2P_PARITY_EN
    if (done) state_d = S2P_PARITY;
    word_strobe = state_q == S2P_PARITY && !sync;
`else
    word_strobe = done;
`endif
  end
  always_comb begin
    busy = state_q != S2P_IDLE;
    overrun_d = overrun_set || (overrun_q && !clear_flags);
    frame_error_d = frame_set || (frame_error_q && !clear_flags);
`ifdef S2P_PARITY_EN
    parity_error_d = parity_set || (parity_error_q && !clear_flags);
`else
    parity_error_d = 1'b0;
`endif
  end
  s2p_hold_reg #(.w(max_width)) u_hold (
    .reset(reset),
    .clock(clock),
    .word(shift_d),
    .word_strobe(word_strobe),
    .ready(ready),
    .data(data),
    .valid(valid),
    .overrun_set(overrun_set)
  );
  assign overrun = overrun_q;
  assign frame_error = frame_error_q;
`ifdef S2P_PARITY_EN
  assign parity_error = parity_error_q;
`endif
endmodule
